// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    // Controller states; the unused code 2'd3 recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width: clog2 of the operand width, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one operand bit per clock through a single adder cell.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             load_c;
    logic             shift_c;
    logic             fa_sum;
    logic             fa_cout;

    // The one adder cell, fed from the operand LSBs and the carry flop.
    full_adder fa0 (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_valid && start_ready) begin
                    load_c    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                shift_c = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand/sum shift registers, carry flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load_c) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            sum_sr <= '0;
            carry  <= cin_in;
            cnt    <= '0;
        end else if (shift_c) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
        end
    end

    // Handshake/status flags registered from the next state, so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done_valid  <= 1'b0;
        end else begin
            start_ready <= (state_nxt == ST_IDLE);
            busy        <= (state_nxt == ST_RUN);
            done_valid  <= (state_nxt == ST_DONE);
        end
    end

    assign sum_out  = sum_sr;
    assign cout_out = carry;

endmodule
